// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared definitions for the MCU UART receiver: receive FSM    |
// |               state encoding, frame width and default bit divider.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package uart_pkg;

    // Data bits per frame (8N1, LSB first)
    localparam int UART_BITS        = 8;

    // 100 MHz system clock / 2 MBPS line rate
    localparam int DEFAULT_BAUD_DIV = 50;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_if                                                   |
// | Description : Consumer-side bundle of the UART receiver: FIFO head with    |
// |               valid/ready pop handshake, FIFO-full status and the          |
// |               framing / overrun error pulses.                              |
// |   rdata  : FIFO head byte, valid while rvalid=1                            |
// |   rvalid : FIFO not empty                                                  |
// |   rready : consumer pops head on rvalid && rready                          |
// |   full   : FIFO full                                                       |
// |   ferr   : one-clk pulse, stop bit sampled low                             |
// |   ovf    : one-clk pulse, good byte dropped because FIFO full              |
// |   master = receiver side, slave = consumer side                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface uart_rx_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic       full;
    logic       ferr;
    logic       ovf;

    modport master (
        output rdata,
        output rvalid,
        output full,
        output ferr,
        output ovf,
        input  rready
    );

    modport slave (
        input  rdata,
        input  rvalid,
        input  full,
        input  ferr,
        input  ovf,
        output rready
    );
endinterface : uart_rx_if
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_fifo                                                 |
// | Description : Synchronous first-word-fall-through byte FIFO.               |
// |               o_dout shows the head entry whenever o_empty=0 and reads 0   |
// |               when empty. A push into a full FIFO is accepted only when a  |
// |               pop happens in the same cycle; a pop when empty is ignored.  |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   i_push/i_din : write request and data                                    |
// |   i_pop        : remove head entry                                         |
// |   o_dout, o_empty, o_full : head data and status                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_push,
    input  wire logic [UART_BITS-1:0] i_din,
    input  wire logic                 i_pop,
    output logic      [UART_BITS-1:0] o_dout,
    output logic                      o_empty,
    output logic                      o_full
);
    localparam logic [FIFO_AW:0] c_DEPTH = (FIFO_AW+1)'(2**FIFO_AW);

    logic [UART_BITS-1:0] r_mem [0:(2**FIFO_AW)-1];
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW:0]     r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_DEPTH);
    assign w_do_pop  = i_pop && !o_empty;
    // A simultaneous pop frees the slot, so a full FIFO still takes the byte
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage is not reset; the empty gate on o_dout hides stale contents
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (FIFO_AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (FIFO_AW+1)'(1);
            end
        end
    end
endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx                                                      |
// | Description : MCU-side UART receiver, 8N1 LSB first. Oversamples rxd with  |
// |               clk, frames bytes and pushes good bytes into an FWFT FIFO    |
// |               read through a valid/ready handshake. Flags framing errors   |
// |               (ferr) and overruns (ovf) as one-clk pulses.                 |
// |   clk   : system clock                                                     |
// |   rst_n : asynchronous active-low reset                                    |
// |   rxd   : serial input, idle high, asynchronous to clk                     |
// |   bus   : uart_rx_if.master (rdata, rvalid, rready, full, ferr, ovf)       |
// | Parameters  : BAUD_DIV (clk per bit, 8..65535), FIFO_AW (depth=2**FIFO_AW) |
// | Option      : UART_RX_MAJORITY_EN - bit value is 2-of-3 majority of the    |
// |               synchronised line at cnt==2,1,0 instead of cnt==0 alone.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int FIFO_AW  = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic rxd,
    uart_rx_if.master bus
);
    localparam int             c_BW     = $clog2(UART_BITS);
    localparam logic [15:0]    c_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [15:0]    c_HALF   = 16'(BAUD_DIV / 2 - 1);
    localparam logic [c_BW-1:0] c_LAST  = c_BW'(UART_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [1:0]           r_fill;
    logic                 r_armed;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [15:0]          r_cnt;
    logic [15:0]          w_cnt_nxt;
    logic [c_BW-1:0]      r_bit;
    logic [c_BW-1:0]      w_bit_nxt;
    logic [UART_BITS-1:0] r_sr;
    logic [UART_BITS-1:0] w_sr_nxt;
    logic                 w_push;
    logic                 w_ferr_set;
    logic                 r_ferr;
    logic                 r_ovf;
    logic                 w_rxd_s;
    logic                 w_tick;
    logic                 w_fall;
    logic                 w_sample;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;

    assign w_rxd_s = r_sync2;
    assign w_tick  = (r_cnt == '0);
    assign w_fall  = r_armed && r_prev && !w_rxd_s;

    // Input synchroniser, edge history and arming. r_fill marks when the
    // synchroniser holds real line samples rather than its reset value, so a
    // line held low across reset release can never arm the receiver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= w_rxd_s;
            r_fill  <= {r_fill[0], 1'b1};
            if (r_fill[1] && w_rxd_s) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic r_s2;
    logic r_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_cnt == 16'd2) r_s2 <= w_rxd_s;
            if (r_cnt == 16'd1) r_s1 <= w_rxd_s;
        end
    end

    assign w_sample = (r_s2 & r_s1) | (r_s2 & w_rxd_s) | (r_s1 & w_rxd_s);
`else
    assign w_sample = w_rxd_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_sr_nxt    = r_sr;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;

        // Bit timer free-runs only while a frame is being sampled
        if (r_state == ST_START || r_state == ST_DATA || r_state == ST_STOP) begin
            w_cnt_nxt = w_tick ? c_RELOAD : (r_cnt - 16'd1);
        end

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = c_HALF;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (!w_sample) begin
                        w_state_nxt = ST_DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_sr_nxt  = {w_sample, r_sr[UART_BITS-1:1]};
                    w_bit_nxt = r_bit + c_BW'(1);
                    if (r_bit == c_LAST) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Leave at the stop-bit centre so a back-to-back start edge
                // arriving within the next half bit is still caught
                if (w_tick) begin
                    if (w_sample) begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (w_rxd_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_sr   <= '0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_bit  <= w_bit_nxt;
            r_sr   <= w_sr_nxt;
            r_ferr <= w_ferr_set;
            // Full implies non-empty, so rready alone tells whether a pop frees a slot
            r_ovf  <= w_push && w_fifo_full && !bus.rready;
        end
    end

    uart_rx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_sr_nxt),
        .i_pop   (bus.rready),
        .o_dout  (bus.rdata),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign bus.rvalid = !w_fifo_empty;
    assign bus.full   = w_fifo_full;
    assign bus.ferr   = r_ferr;
    assign bus.ovf    = r_ovf;
endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx                                                   |
// | Description : Directed self-checking bench for uart_rx. Drives 8N1 frames  |
// |               at BAUD_DIV=50 (10 ns clk), records popped bytes and error   |
// |               pulses, and compares against hand-computed values. Expected  |
// |               glitch-test result depends on UART_RX_MAJORITY_EN.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_rx;
    localparam int c_DIV = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .BAUD_DIV (c_DIV),
        .FIFO_AW  (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] popq[$];
    int         n_ferr   = 0;
    int         n_ovf    = 0;

    // Monitor: one entry per accepted pop, one count per error pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rvalid && bus.rready) popq.push_back(bus.rdata);
            if (bus.ferr) n_ferr++;
            if (bus.ovf)  n_ovf++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pop_at(input int idx);
        if (idx < popq.size()) return {24'd0, popq[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    // One frame: start, 8 data bits LSB first, stop. stop_low>0 holds the
    // stop bit low for that many bit times. glitch3 puts a one-clk high pulse
    // on rxd positioned so it reaches the synchronised line exactly on the
    // bit-3 centre sample cycle.
    task automatic send_frame(input logic [7:0] data, input int stop_low, input bit glitch3);
        @(posedge clk);
        #1;
        rxd = 1'b0;
        wait_cyc(c_DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            if (glitch3 && i == 3) begin
                wait_cyc(25);
                rxd = 1'b1;
                wait_cyc(1);
                rxd = data[i];
                wait_cyc(24);
            end else begin
                wait_cyc(c_DIV);
            end
        end
        if (stop_low > 0) begin
            rxd = 1'b0;
            wait_cyc(c_DIV * stop_low);
        end
        rxd = 1'b1;
        wait_cyc(c_DIV);
    endtask

    int         base_q;
    int         base_f;
    int         base_o;
    logic [7:0] exp_glitch;

    initial begin
        bus.rready = 1'b0;

        // Reset state
        wait_cyc(3);
        check_eq("rst_rdata",  {24'd0, bus.rdata}, 32'h00);
        check_eq("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check_eq("rst_full",   {31'd0, bus.full},   32'd0);
        check_eq("rst_ferr",   {31'd0, bus.ferr},   32'd0);
        check_eq("rst_ovf",    {31'd0, bus.ovf},    32'd0);
        rst_n = 1'b1;
        wait_cyc(20);

        // 1: two back-to-back bytes with consumer ready
        bus.rready = 1'b1;
        base_q = popq.size(); base_f = n_ferr; base_o = n_ovf;
        send_frame(8'h55, 0, 1'b0);
        send_frame(8'hA3, 0, 1'b0);
        wait_cyc(10);
        check_eq("t1_count", popq.size() - base_q, 2);
        check_eq("t1_b0",    pop_at(base_q),     32'h55);
        check_eq("t1_b1",    pop_at(base_q + 1), 32'hA3);
        check_eq("t1_ferr",  n_ferr - base_f, 0);
        check_eq("t1_ovf",   n_ovf - base_o,  0);

        // 2: 200 ns low glitch rejected by the start-bit check
        base_q = popq.size(); base_f = n_ferr;
        rxd = 1'b0;
        wait_cyc(20);
        rxd = 1'b1;
        wait_cyc(100);
        check_eq("t2_count",  popq.size() - base_q, 0);
        check_eq("t2_ferr",   n_ferr - base_f, 0);
        check_eq("t2_rvalid", {31'd0, bus.rvalid}, 32'd0);

        // 3: stop bit low for two bit times, then a good frame
        base_q = popq.size(); base_f = n_ferr;
        send_frame(8'h7E, 2, 1'b0);
        wait_cyc(20);
        check_eq("t3_ferr",   n_ferr - base_f, 1);
        check_eq("t3_count",  popq.size() - base_q, 0);
        check_eq("t3_rvalid", {31'd0, bus.rvalid}, 32'd0);
        send_frame(8'h12, 0, 1'b0);
        wait_cyc(5);
        check_eq("t3_b0",     pop_at(base_q), 32'h12);
        check_eq("t3_ferr2",  n_ferr - base_f, 1);

        // 4: fill to full, overrun on 17th, drain in order
        bus.rready = 1'b0;
        base_q = popq.size(); base_o = n_ovf;
        for (int b = 0; b < 15; b++) send_frame(8'(b), 0, 1'b0);
        check_eq("t4_full15",  {31'd0, bus.full}, 32'd0);
        send_frame(8'h0F, 0, 1'b0);
        check_eq("t4_full16",  {31'd0, bus.full}, 32'd1);
        check_eq("t4_ovf16",   n_ovf - base_o, 0);
        check_eq("t4_head",    {24'd0, bus.rdata}, 32'h00);
        send_frame(8'h10, 0, 1'b0);
        check_eq("t4_ovf17",   n_ovf - base_o, 1);
        check_eq("t4_full17",  {31'd0, bus.full}, 32'd1);
        bus.rready = 1'b1;
        wait_cyc(30);
        check_eq("t4_count",   popq.size() - base_q, 16);
        for (int b = 0; b < 16; b++) begin
            check_eq($sformatf("t4_drain%0d", b), pop_at(base_q + b), 32'(b));
        end
        check_eq("t4_rvalid",  {31'd0, bus.rvalid}, 32'd0);
        check_eq("t4_fulldn",  {31'd0, bus.full},   32'd0);

        // 5: reset mid-frame with line low, release while low
        bus.rready = 1'b0;
        send_frame(8'h5A, 0, 1'b0);
        check_eq("t5_pre_rvalid", {31'd0, bus.rvalid}, 32'd1);
        rxd = 1'b0;
        wait_cyc(100);
        rst_n = 1'b0;
        wait_cyc(3);
        check_eq("t5_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        rst_n = 1'b1;
        bus.rready = 1'b1;
        base_q = popq.size(); base_f = n_ferr;
        wait_cyc(600);
        check_eq("t5_count",  popq.size() - base_q, 0);
        check_eq("t5_ferr",   n_ferr - base_f, 0);
        check_eq("t5_rvalid", {31'd0, bus.rvalid}, 32'd0);
        rxd = 1'b1;
        wait_cyc(10);
        send_frame(8'hC3, 0, 1'b0);
        wait_cyc(5);
        check_eq("t5_b0",     pop_at(base_q), 32'hC3);
        check_eq("t5_count2", popq.size() - base_q, 1);

        // 6: one-clk high pulse at bit-3 centre of a 00h frame
`ifdef UART_RX_MAJORITY_EN
        exp_glitch = 8'h00;
`else
        exp_glitch = 8'h08;
`endif
        base_q = popq.size();
        send_frame(8'h00, 0, 1'b1);
        wait_cyc(5);
        check_eq("t6_count", popq.size() - base_q, 1);
        check_eq("t6_b0",    pop_at(base_q), {24'd0, exp_glitch});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule : tb_uart_rx
`default_nettype wire
